fc_feature_streamer: RTL
========================

Name: fc_feature_streamer

Overview:
Transmit side of the fully-connected layer input interface. On start, reads the flattened pooled feature vector (INPUT_SIZE words) from the feature buffer and streams it to the Fully_connected block. The stream uses a valid/ready handshake and marks the final word. After the last word, it waits for the layer's FC_done and then reports completion to the layer sequencer.

Parameters:
DATA_WIDTH, 16, activation word width (matches Fully_connected)
INPUT_SIZE, 400, number of words streamed per start (flattened 16x5x5)
ADDR_WIDTH, $clog2(INPUT_SIZE) = 9, feature buffer address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to stream one vector; ignored while busy
busy  out  1  high from accepted start until done pulse
done  out  1  one-cycle pulse: vector sent and fc_done observed
mem_rd_en  out  1  feature buffer read strobe
mem_rd_addr  out  ADDR_WIDTH  feature buffer read address
mem_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
out_data  out  DATA_WIDTH  stream word to FC
out_valid  out  1  stream word valid
out_ready  in  1  FC accepts word when out_valid and out_ready are both high
out_last  out  1  high with the word at index INPUT_SIZE-1
fc_done  in  1  FC_done from Fully_connected

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rst_n). All state clears immediately on rst_n low.
- Reset values: busy=0, done=0, out_valid=0, out_last=0, out_data=0, mem_rd_en=0, mem_rd_addr=0. Internal state: FSM=IDLE, counters=0, buffer empty.
- FSM states:
  - IDLE: start=1 -> STREAM; busy rises next cycle; read address counter and sent counter are 0.
  - STREAM: issue reads at addresses 0..INPUT_SIZE-1 in order. After the read of INPUT_SIZE-1 is issued -> DRAIN.
  - DRAIN: no new reads. On the handshake of the out_last word -> WAIT_FC.
  - WAIT_FC: fc_done=1 -> done=1 for exactly the next cycle, busy=0 in that same cycle, state IDLE.
- Flow control: 2-entry output buffer, with credit = occupancy + reads in flight.
  - mem_rd_en is asserted only when credit < 2, or when credit == 2 and a handshake occurs in the same cycle.
  - Read data is written into the buffer the cycle after mem_rd_en.
  - No word is ever dropped or duplicated under any out_ready pattern.
- Latency: start at cycle 0 -> first mem_rd_en at cycle 1 -> out_valid at cycle 2.
- Throughput: with out_ready held 1, one word per cycle. Last handshake at cycle INPUT_SIZE+1 (cycle 401 at the default size).
- out_valid/out_data/out_last hold stable while out_valid=1 and out_ready=0 (AXI-style rule; valid never depends on ready).
- out_last=1 only on the word from address INPUT_SIZE-1.
- start while busy: ignored, with no effect on counters.
- start in the same cycle as a done pulse: ignored. A new start is accepted the following cycle.
- fc_done outside WAIT_FC: ignored, not latched.
- rst_n low mid-stream: outputs return to reset values asynchronously. A partial vector is abandoned; after release, a new start restarts at address 0.
- Counters are ADDR_WIDTH+1 bits so that terminal detection at INPUT_SIZE does not wrap.

Decomposition:
- Shared package lenet_pkg:
  - DATA_WIDTH
  - FC1_IN_SIZE=400, FC1_OUT_SIZE=120
  - fc_stream_state_t enum {IDLE, STREAM, DRAIN, WAIT_FC}
- Sub-module stream_skid_buf: 2-entry register FIFO with push/pop/count and a data+last payload. It is reused by later layer streamers.

Test Plan:
- Memory holds data[i]=i+16'h100; out_ready=1; start at cycle 0 -> 400 handshakes at cycles 2..401, out_data = 0x100..0x28F in order, out_last only on 0x28F, busy=1 during cycles 1..done.
- out_ready randomized (50% duty, seeded) -> scoreboard sees exactly 400 words, in order, none duplicated; outputs stable while stalled; out_last exactly once.
- out_ready held 0 from cycle 0 -> exactly 2 mem_rd_en pulses (addresses 0,1), then none; out_data=0x100 stable. Releasing ready resumes with 0x101, 0x102, ...
- Second start asserted at cycle 50 during streaming -> ignored: total still 400 words, single done.
- fc_done pulsed at cycle 100 (STREAM), then at cycle 410 (WAIT_FC) -> no done at 101; done=1 at cycle 411 only, busy=0 at 411.
- rst_n low at cycle 150 for 3 cycles -> out_valid=0, busy=0 immediately. Then start -> stream restarts at 0x100, full 400 words, normal done.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared LeNet datapath constants and stream-control types.
package lenet_pkg;

    localparam int unsigned DATA_WIDTH   = 16;
    localparam int unsigned FC1_IN_SIZE  = 400;
    localparam int unsigned FC1_OUT_SIZE = 120;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        WAIT_FC
    } fc_stream_state_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry register FIFO used as the output skid buffer of layer streamers.
module stream_skid_buf #(
    parameter int unsigned WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entry0_q, entry1_q;
    logic [1:0]       count_q, count_d;
    logic [1:0]       wr_slot;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // Slot the pushed word lands in after any simultaneous pop shifts the queue.
        wr_slot = count_q - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else begin
            count_q <= count_d;
            if (pop) begin
                entry0_q <= entry1_q;
            end
            if (push) begin
                if (wr_slot == 2'd0) begin
                    entry0_q <= wr_data;
                end else begin
                    entry1_q <= wr_data;
                end
            end
        end
    end

    assign rd_data = entry0_q;
    assign count   = count_q;

endmodule

// File: rtl/fc_feature_streamer.sv
// Streams the flattened feature vector from the feature buffer to the FC layer
// over a valid/ready link, then waits for fc_done before reporting done.
module fc_feature_streamer
    import lenet_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = lenet_pkg::DATA_WIDTH,
    parameter int unsigned INPUT_SIZE = FC1_IN_SIZE,
    parameter int unsigned ADDR_WIDTH = $clog2(INPUT_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    input  logic                  fc_done
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(INPUT_SIZE - 1);

    fc_stream_state_t     state_q, state_d;
    logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic                 inflight_q, inflight_last_q;
    logic                 done_q, done_d;

    logic                  buf_push, buf_pop, buf_valid, hs, can_read;
    logic [1:0]            buf_count, credit;
    logic [DATA_WIDTH:0]   buf_head;

    stream_skid_buf #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (buf_push),
        .pop     (buf_pop),
        .wr_data ({inflight_last_q, mem_rd_data}),
        .rd_data (buf_head),
        .count   (buf_count)
    );

    // An arriving read word bypasses the empty buffer so the first word is
    // presented the cycle its data returns.
    always_comb begin
        buf_valid = (buf_count != 2'd0);
        out_valid = buf_valid | inflight_q;
        if (buf_valid) begin
            {out_last, out_data} = buf_head;
        end else if (inflight_q) begin
            {out_last, out_data} = {inflight_last_q, mem_rd_data};
        end else begin
            {out_last, out_data} = '0;
        end
        hs       = out_valid & out_ready;
        buf_pop  = hs & buf_valid;
        buf_push = inflight_q & ~(hs & ~buf_valid);
        credit   = buf_count + {1'b0, inflight_q};
        can_read = (credit < 2'd2) | ((credit == 2'd2) & hs);
    end

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        done_d    = 1'b0;
        mem_rd_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                // done_q blocks a start arriving alongside the done pulse.
                if (start && !done_q) begin
                    state_d  = STREAM;
                    rd_cnt_d = '0;
                end
            end
            STREAM: begin
                if (can_read) begin
                    mem_rd_en = 1'b1;
                    rd_cnt_d  = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (hs && out_last) begin
                    state_d = WAIT_FC;
                end
            end
            WAIT_FC: begin
                if (fc_done) begin
                    state_d  = IDLE;
                    rd_cnt_d = '0;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            rd_cnt_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_cnt_q        <= rd_cnt_d;
            inflight_q      <= mem_rd_en;
            inflight_last_q <= mem_rd_en && (rd_cnt_q == LAST_IDX);
            done_q          <= done_d;
        end
    end

    assign mem_rd_addr = rd_cnt_q[ADDR_WIDTH-1:0];
    assign busy        = (state_q != IDLE);
    assign done        = done_q;

endmodule
